// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction codes, primary opcodes and R-type funct values.
package mips_pkg;

   // Request opcode codes as presented on req_op; anything above OP_JAL is illegal.
   typedef enum logic [4:0] {
      OP_ADD  = 5'd0,
      OP_SUB  = 5'd1,
      OP_AND  = 5'd2,
      OP_OR   = 5'd3,
      OP_SLT  = 5'd4,
      OP_JR   = 5'd5,
      OP_LW   = 5'd6,
      OP_SW   = 5'd7,
      OP_BEQ  = 5'd8,
      OP_BNE  = 5'd9,
      OP_ADDI = 5'd10,
      OP_J    = 5'd11,
      OP_LUI  = 5'd12,
      OP_ORI  = 5'd13,
      OP_ANDI = 5'd14,
      OP_XORI = 5'd15,
      OP_JAL  = 5'd16
   } instr_t;

   localparam logic [4:0] OP_LAST = 5'd16;

   // Primary opcode field (bits 31:26)
   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_BNE   = 6'b000101;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;
   localparam logic [5:0] OPC_ORI   = 6'b001101;
   localparam logic [5:0] OPC_ANDI  = 6'b001100;
   localparam logic [5:0] OPC_XORI  = 6'b001110;
   localparam logic [5:0] OPC_LUI   = 6'b001111;
   localparam logic [5:0] OPC_J     = 6'b000010;
   localparam logic [5:0] OPC_JAL   = 6'b000011;

   // R-type funct field (bits 5:0)
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   // True when a raw request code maps onto a defined instruction.
   function automatic logic is_legal(input logic [4:0] code);
      return (code <= OP_LAST);
   endfunction

endpackage

// File: rtl/mips_enc_fifo.sv
// Two-entry FIFO holding encoded words until the instruction memory accepts them.
module mips_enc_fifo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_reg [2];
   logic             wr_ptr_reg;
   logic             rd_ptr_reg;
   logic [1:0]       count_reg;
   logic             do_push;
   logic             do_pop;

   // Guard against overflow/underflow so a misbehaving caller cannot corrupt state.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage, pointers and occupancy; a push and pop together leave occupancy unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_reg[0] <= '0;
         mem_reg[1] <= '0;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_reg[wr_ptr_reg] <= wdata;
            wr_ptr_reg          <= ~wr_ptr_reg;
         end
         if (do_pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign rdata = mem_reg[rd_ptr_reg];
   assign full  = (count_reg == 2'd2);
   assign empty = (count_reg == 2'd0);

endmodule

// File: rtl/mips_instr_encoder.sv
// Encodes MIPS instruction requests into 32-bit words and streams them into instruction memory.
module mips_instr_encoder
   import mips_pkg::*;
#(
   parameter int IMEM_AW = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [4:0]         req_op,
   input  logic [4:0]         req_rs,
   input  logic [4:0]         req_rt,
   input  logic [4:0]         req_rd,
   input  logic [4:0]         req_shamt,
   input  logic [15:0]        req_imm,
   input  logic [25:0]        req_target,
   input  logic               base_load,
   input  logic [IMEM_AW-1:0] base_addr,
   input  logic               imem_ready,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [31:0]        imem_wd,
   output logic [IMEM_AW:0]   wr_count,
   output logic               err_illegal,
   input  logic               err_clr
);

   localparam logic [IMEM_AW:0] WR_MAX = {1'b1, {IMEM_AW{1'b0}}};

   instr_t             op_code;
   logic [31:0]        enc_word;
   logic               accept;
   logic               op_legal;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [IMEM_AW-1:0] addr_reg;
   logic [IMEM_AW:0]   wr_count_reg;
   logic               err_reg;
   logic               unused_shamt;

   // No supported format carries a shift amount, so the field is deliberately ignored.
   assign unused_shamt = ^req_shamt;

   assign op_code  = instr_t'(req_op);
   assign op_legal = is_legal(req_op);
   assign accept   = req_valid && req_ready;
   assign push     = accept && op_legal;
   assign pop      = imem_we && imem_ready;

   // Build the instruction word; fields a format does not use are tied to zero.
   always_comb begin
      enc_word = '0;
      case (op_code)
         OP_ADD:  enc_word = {OPC_RTYPE, req_rs, req_rt, req_rd, 5'b0, FN_ADD};
         OP_SUB:  enc_word = {OPC_RTYPE, req_rs, req_rt, req_rd, 5'b0, FN_SUB};
         OP_AND:  enc_word = {OPC_RTYPE, req_rs, req_rt, req_rd, 5'b0, FN_AND};
         OP_OR:   enc_word = {OPC_RTYPE, req_rs, req_rt, req_rd, 5'b0, FN_OR};
         OP_SLT:  enc_word = {OPC_RTYPE, req_rs, req_rt, req_rd, 5'b0, FN_SLT};
         OP_JR:   enc_word = {OPC_RTYPE, req_rs, 15'b0, FN_JR};
         OP_LW:   enc_word = {OPC_LW,   req_rs, req_rt, req_imm};
         OP_SW:   enc_word = {OPC_SW,   req_rs, req_rt, req_imm};
         OP_BEQ:  enc_word = {OPC_BEQ,  req_rs, req_rt, req_imm};
         OP_BNE:  enc_word = {OPC_BNE,  req_rs, req_rt, req_imm};
         OP_ADDI: enc_word = {OPC_ADDI, req_rs, req_rt, req_imm};
         OP_ORI:  enc_word = {OPC_ORI,  req_rs, req_rt, req_imm};
         OP_ANDI: enc_word = {OPC_ANDI, req_rs, req_rt, req_imm};
         OP_XORI: enc_word = {OPC_XORI, req_rs, req_rt, req_imm};
         OP_LUI:  enc_word = {OPC_LUI,  5'b0,   req_rt, req_imm};
         OP_J:    enc_word = {OPC_J,    req_target};
         OP_JAL:  enc_word = {OPC_JAL,  req_target};
         default: enc_word = '0;
      endcase
   end

   mips_enc_fifo #(
      .WIDTH (32)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (enc_word),
      .pop   (pop),
      .rdata (imem_wd),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Handshake and write strobe derive only from registered FIFO occupancy.
   assign req_ready = ~fifo_full;
   assign imem_we   = ~fifo_empty;

   // Write address and completed-write count; a base load overrides a coincident pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_reg     <= '0;
         wr_count_reg <= '0;
      end else if (base_load) begin
         addr_reg     <= base_addr;
         wr_count_reg <= '0;
      end else if (pop) begin
         addr_reg <= addr_reg + (IMEM_AW)'(1);
         if (wr_count_reg != WR_MAX) begin
            wr_count_reg <= wr_count_reg + (IMEM_AW + 1)'(1);
         end
      end
   end

   // Sticky illegal-op flag; a new illegal accept takes priority over a clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_reg <= 1'b0;
      end else if (accept && !op_legal) begin
         err_reg <= 1'b1;
      end else if (err_clr) begin
         err_reg <= 1'b0;
      end
   end

   assign imem_addr   = addr_reg;
   assign wr_count    = wr_count_reg;
   assign err_illegal = err_reg;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: stimulus queues expected writes, a monitor checks them.
module tb_mips_instr_encoder;

   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [4:0]    req_op;
   logic [4:0]    req_rs;
   logic [4:0]    req_rt;
   logic [4:0]    req_rd;
   logic [4:0]    req_shamt;
   logic [15:0]   req_imm;
   logic [25:0]   req_target;
   logic          base_load;
   logic [AW-1:0] base_addr;
   logic          imem_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wd;
   logic [AW:0]   wr_count;
   logic          err_illegal;
   logic          err_clr;

   int checks = 0;
   int errors = 0;

   logic [31:0]   exp_word_q [$];
   logic [AW-1:0] exp_addr_q [$];
   logic [AW-1:0] exp_addr = '0;

   mips_instr_encoder #(.IMEM_AW(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_rs      (req_rs),
      .req_rt      (req_rt),
      .req_rd      (req_rd),
      .req_shamt   (req_shamt),
      .req_imm     (req_imm),
      .req_target  (req_target),
      .base_load   (base_load),
      .base_addr   (base_addr),
      .imem_ready  (imem_ready),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wd     (imem_wd),
      .wr_count    (wr_count),
      .err_illegal (err_illegal),
      .err_clr     (err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request, wait (bounded) for acceptance, and queue the expected write if legal.
   task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic [31:0] exp_w, input logic legal);
      bit ok;
      ok = 1'b0;
      req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_shamt = sh;
      req_imm = imm; req_target = tgt;
      req_valid = 1'b1;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (req_ready === 1'b1) ok = 1'b1;
         tick();
      end
      req_valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: op=%0d never accepted, required acceptance within 60 cycles", op);
      end else if (legal) begin
         exp_word_q.push_back(exp_w);
         exp_addr_q.push_back(exp_addr);
         exp_addr = exp_addr + 1'b1;
      end
   endtask

   task automatic do_base_load(input logic [AW-1:0] a);
      base_load = 1'b1;
      base_addr = a;
      tick();
      base_load = 1'b0;
      exp_addr  = a;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_word_q.size() != 0 || imem_we === 1'b1) && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d writes outstanding, required 0", exp_word_q.size());
      end
   endtask

   // Monitor: every write the memory accepts must match the head of the scoreboard.
   initial begin : monitor
      logic [31:0]   w;
      logic [AW-1:0] a;
      forever begin
         @(negedge clk);
         if (imem_we === 1'b1 && imem_ready === 1'b1) begin
            if (exp_word_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr=%0d wd=%h, required no write", imem_addr, imem_wd);
            end else begin
               w = exp_word_q.pop_front();
               a = exp_addr_q.pop_front();
               chk("write_addr", 32'(imem_addr), 32'(a));
               chk("write_data", imem_wd, w);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      reset = 1'b0; req_valid = 1'b0; req_op = '0; req_rs = '0; req_rt = '0; req_rd = '0;
      req_shamt = '0; req_imm = '0; req_target = '0; base_load = 1'b0; base_addr = '0;
      imem_ready = 1'b0; err_clr = 1'b0;

      // Reset state
      #12;
      chk("reset_we",       32'(imem_we),     32'd0);
      chk("reset_addr",     32'(imem_addr),   32'd0);
      chk("reset_wd",       imem_wd,          32'd0);
      chk("reset_wr_count", 32'(wr_count),    32'd0);
      chk("reset_err",      32'(err_illegal), 32'd0);
      chk("reset_ready",    32'(req_ready),   32'd1);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // One-cycle latency: ADD rs=1 rt=2 rd=3 shamt=7 at base 0
      imem_ready = 1'b1;
      send(5'd0, 5'd1, 5'd2, 5'd3, 5'd7, 16'hFFFF, 26'h3FFFFFF, 32'h00221820, 1'b1);
      chk("latency_we",   32'(imem_we),   32'd1);
      chk("latency_addr", 32'(imem_addr), 32'd0);
      chk("latency_wd",   imem_wd,        32'h00221820);
      wait_drain();
      chk("wr_count_1", 32'(wr_count), 32'd1);

      // Back-to-back formats; unused fields fed with non-zero junk
      send(5'd6,  5'd1,  5'd2,  5'd31, 5'd31, 16'h0004, 26'h3FFFFFF, 32'h8C220004, 1'b1); // LW
      send(5'd16, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000010, 32'h0C000010, 1'b1); // JAL
      send(5'd12, 5'd9,  5'd1,  5'd31, 5'd31, 16'hABCD, 26'h3FFFFFF, 32'h3C01ABCD, 1'b1); // LUI
      send(5'd1,  5'd4,  5'd5,  5'd6,  5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h00853022, 1'b1); // SUB
      send(5'd5,  5'd31, 5'd3,  5'd4,  5'd5,  16'hFFFF, 26'h3FFFFFF, 32'h03E00008, 1'b1); // JR
      send(5'd8,  5'd2,  5'd3,  5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h1043FFFF, 1'b1); // BEQ
      send(5'd11, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h0BFFFFFF, 1'b1); // J
      send(5'd13, 5'd7,  5'd8,  5'd31, 5'd31, 16'h1234, 26'h3FFFFFF, 32'h34E81234, 1'b1); // ORI
      send(5'd4,  5'd1,  5'd1,  5'd1,  5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h0021082A, 1'b1); // SLT
      send(5'd15, 5'd0,  5'd31, 5'd31, 5'd31, 16'h0001, 26'h3FFFFFF, 32'h381F0001, 1'b1); // XORI
      wait_drain();
      chk("wr_count_11", 32'(wr_count), 32'd11);

      // Back-pressure: two accepts fill the FIFO, third waits until memory is ready
      do_base_load('0);
      chk("base_clears_count", 32'(wr_count), 32'd0);
      imem_ready = 1'b0;
      send(5'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 32'h00853022, 1'b1);
      send(5'd8, 5'd2, 5'd3, 5'd0, 5'd0, 16'hFFFF, 26'h0, 32'h1043FFFF, 1'b1);
      chk("full_ready", 32'(req_ready), 32'd0);
      fork
         send(5'd15, 5'd0, 5'd31, 5'd0, 5'd0, 16'h0001, 26'h0, 32'h381F0001, 1'b1);
         begin
            repeat (3) tick();
            chk("stall_we",   32'(imem_we),   32'd1);
            chk("stall_addr", 32'(imem_addr), 32'd0);
            chk("stall_wd",   imem_wd,        32'h00853022);
            imem_ready = 1'b1;
         end
      join
      wait_drain();
      chk("wr_count_3", 32'(wr_count), 32'd3);

      // Address wrap from 63
      do_base_load(6'd63);
      send(5'd10, 5'd3, 5'd4, 5'd0, 5'd0, 16'h8000, 26'h0, 32'h20648000, 1'b1); // ADDI
      send(5'd2,  5'd8, 5'd9, 5'd10, 5'd0, 16'h0,   26'h0, 32'h01095024, 1'b1); // AND
      wait_drain();
      chk("wrap_wr_count", 32'(wr_count),  32'd2);
      chk("wrap_next_addr", 32'(imem_addr), 32'd1);

      // Illegal op: no write, sticky flag, set beats clear
      send(5'd20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0, 1'b0);
      chk("illegal_err",   32'(err_illegal), 32'd1);
      chk("illegal_ready", 32'(req_ready),   32'd1);
      repeat (3) tick();
      chk("illegal_sticky", 32'(err_illegal), 32'd1);
      chk("illegal_no_we",  32'(imem_we),     32'd0);
      chk("illegal_count",  32'(wr_count),    32'd2);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_cleared", 32'(err_illegal), 32'd0);
      err_clr = 1'b1;
      send(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0, 1'b0);
      err_clr = 1'b0;
      chk("err_set_wins", 32'(err_illegal), 32'd1);

      // Base load coincident with a pop: popped word at old address, counter reloads
      do_base_load(6'd5);
      imem_ready = 1'b0;
      send(5'd3, 5'd1,  5'd2,  5'd3, 5'd0, 16'h0,    26'h0, 32'h00221825, 1'b1); // OR
      send(5'd7, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0010, 26'h0, 32'hAFBF0010, 1'b1); // SW
      exp_addr_q[1] = 6'd10;
      imem_ready = 1'b1;
      base_load  = 1'b1;
      base_addr  = 6'd10;
      tick();
      base_load = 1'b0;
      exp_addr  = 6'd11;
      wait_drain();
      chk("bl_pop_count", 32'(wr_count),  32'd1);
      chk("bl_pop_addr",  32'(imem_addr), 32'd11);

      // Asynchronous reset while the FIFO is full
      imem_ready = 1'b0;
      send(5'd14, 5'd2, 5'd3, 5'd0, 5'd0, 16'h00FF, 26'h0, 32'h304300FF, 1'b1); // ANDI
      send(5'd9,  5'd4, 5'd5, 5'd0, 5'd0, 16'h0002, 26'h0, 32'h14850002, 1'b1); // BNE
      chk("prerst_ready", 32'(req_ready), 32'd0);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_we",    32'(imem_we),     32'd0);
      chk("rst_ready", 32'(req_ready),   32'd1);
      chk("rst_addr",  32'(imem_addr),   32'd0);
      chk("rst_wd",    imem_wd,          32'd0);
      chk("rst_count", 32'(wr_count),    32'd0);
      chk("rst_err",   32'(err_illegal), 32'd0);
      exp_word_q.delete();
      exp_addr_q.delete();
      exp_addr = '0;
      @(negedge clk);
      reset = 1'b1;
      imem_ready = 1'b1;
      repeat (5) tick();
      chk("postrst_we",    32'(imem_we),   32'd0);
      chk("postrst_ready", 32'(req_ready), 32'd1);
      chk("postrst_count", 32'(wr_count),  32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mips_instr_encoder.md
MIPS_INSTR_ENCODER -- requirements
Module: mips_instr_encoder

Interface
REQ-001 SHALL have parameter IMEM_AW, default 6, meaning the word-address width of the instruction memory.
REQ-002 SHALL have port clk, in, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, in, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports req_valid (in, 1) and req_ready (out, 1): the request handshake; a transfer occurs when both are 1 at a rising edge.
REQ-005 SHALL have port req_op, in, 5 bits: instr_t code 0..16 = ADD, SUB, AND, OR, SLT, JR, LW, SW, BEQ, BNE, ADDI, J, LUI, ORI, ANDI, XORI, JAL; codes 17..31 are illegal.
REQ-006 SHALL have ports req_rs, req_rt, req_rd, req_shamt (each in, 5), req_imm (in, 16) and req_target (in, 26): the instruction fields.
REQ-007 SHALL have ports base_load (in, 1) and base_addr (in, IMEM_AW): load the write-address counter.
REQ-008 SHALL have port imem_ready, in, 1 bit: instruction memory accepts a write this cycle.
REQ-009 SHALL have ports imem_we (out, 1), imem_addr (out, IMEM_AW) and imem_wd (out, 32): the instruction-memory write port.
REQ-010 SHALL have port wr_count, out, IMEM_AW+1 bits: completed writes since the last base_load or reset.
REQ-011 SHALL have ports err_illegal (out, 1, sticky illegal-op flag) and err_clr (in, 1, clears it).

Function
REQ-012 SHALL encode each instruction as follows:
- R-type: {6'b0, rs, rt, rd, 5'b0, funct}, with funct ADD=100000, SUB=100010, AND=100100, OR=100101, SLT=101010.
- JR: {6'b0, rs, 15'b0, 001000}.
- I-type: {op, rs, rt, imm}, with op LW=100011, SW=101011, BEQ=000100, BNE=000101, ADDI=001000, ORI=001101, ANDI=001100, XORI=001110.
- LUI: {001111, 5'b0, rt, imm}.
- J and JAL: {000010 or 000011, target}.
REQ-013 SHALL force every field not used by the selected format to zero, regardless of input values.
REQ-014 SHALL, on each accepted legal request, push the encoded word into a 2-entry FIFO.
REQ-015 SHALL drive req_ready = NOT fifo_full, combinationally from registered state only; there is no push-through when the FIFO is full.
REQ-016 SHALL drive imem_we = NOT fifo_empty, with imem_wd = FIFO head and imem_addr = address counter.
REQ-017 SHALL pop the FIFO when imem_we AND imem_ready; on a pop, imem_addr increments modulo 2^IMEM_AW and wr_count increments, saturating at 2^IMEM_AW.
REQ-018 SHALL give a latency of one cycle: a request accepted at edge N into an empty FIFO produces imem_we=1 in the cycle after edge N.
REQ-019 SHALL, on a simultaneous push and pop with 1 entry held, keep the occupancy at 1 and preserve order.
REQ-020 SHALL hold imem_wd and imem_addr stable while imem_we=1 and imem_ready=0.
REQ-021 SHALL, on an accepted illegal req_op, not push, and set err_illegal at that edge; req_ready behaviour is unchanged.
REQ-022 SHALL let set win over clear when err_clr and an illegal accept occur in the same cycle.
REQ-023 SHALL, on base_load, load the address counter from base_addr and clear wr_count.
REQ-024 SHALL let base_load win over a coincident pop's increment: the popped word is written at the old address, and the counter takes base_addr.

Reset
REQ-025 SHALL, while reset=0, immediately and asynchronously force: FIFO empty, imem_we=0, imem_addr=0, imem_wd=0, wr_count=0, err_illegal=0, req_ready=1.
REQ-026 SHALL discard FIFO contents on reset mid-operation; no partial write is issued after reset deasserts.

Structure
REQ-027 SHALL place the instr_t enum and all opcode and funct constants in shared package mips_pkg, reused by the control decoder.
REQ-028 SHALL implement the 2-entry FIFO as sub-module mips_enc_fifo (parameter WIDTH=32); encoding stays combinational in the top level.

Verification
REQ-029 SHALL cover: ADD rs=1 rt=2 rd=3 shamt=7, base 0 -> one cycle later imem_we=1, imem_addr=0, imem_wd=0x00221820.
REQ-030 SHALL cover: LW rs=1 rt=2 imm=0x0004 -> 0x8C220004; JAL target=0x0000010 -> 0x0C000010; LUI rs=9 rt=1 imm=0xABCD -> 0x3C01ABCD.
REQ-031 SHALL cover: imem_ready=0 with 3 valid requests -> req_ready=0 after 2 accepts; imem_ready=1 -> the 3 words are written in order at addresses 0, 1, 2.
REQ-032 SHALL cover: IMEM_AW=6, base_load base_addr=63, 2 writes -> addresses 63 then 0, wr_count=2.
REQ-033 SHALL cover: req_op=20 -> no imem_we, err_illegal=1 until err_clr; err_clr with a simultaneous illegal accept -> err_illegal stays 1.
REQ-034 SHALL cover: FIFO full, reset pulsed low mid-cycle -> imem_we=0 at once; after release, no writes and req_ready=1.
